// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - Hack CPU instruction field positions, defaults and C-instruction decode
package hack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 15;
    localparam int PC_RESET  = 0;

    localparam int TYPE_BIT  = 15;
    localparam int A_BIT     = 12;
    localparam int COMP_MSB  = 11;
    localparam int COMP_LSB  = 6;
    localparam int DEST_MSB  = 5;
    localparam int DEST_LSB  = 3;
    localparam int JMP_MSB   = 2;
    localparam int JMP_LSB   = 0;

    typedef struct packed {
        logic       a;
        logic [5:0] comp;
        logic       dest_a;
        logic       dest_d;
        logic       dest_m;
        logic       lt;
        logic       eq;
        logic       gt;
    } c_fields_t;

    // Bits 14:13 are don't-care, so any instruction with bit 15 set decodes as C.
    function automatic c_fields_t decode_c(input logic [15:0] instr);
        c_fields_t f;
        f.a                     = instr[A_BIT];
        f.comp                  = instr[COMP_MSB:COMP_LSB];
        {f.dest_a, f.dest_d, f.dest_m} = instr[DEST_MSB:DEST_LSB];
        {f.lt, f.eq, f.gt}      = instr[JMP_MSB:JMP_LSB];
        return f;
    endfunction

endpackage

// File: rtl/hack_cpu_core_if.sv
// rtl/hack_cpu_core_if.sv - instruction ROM / data RAM bus seen by the Hack CPU core
interface hack_cpu_core_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 15
);
    logic [15:0]      instruction;
    logic [WIDTH-1:0] inM;
    logic             stall;
    logic [WIDTH-1:0] outM;
    logic             writeM;
    logic [AW-1:0]    addressM;
    logic [AW-1:0]    pc;

    modport master (
        input  instruction, inM, stall,
        output outM, writeM, addressM, pc
    );

    modport slave (
        output instruction, inM, stall,
        input  outM, writeM, addressM, pc
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - Hack ALU: conditional zero/negate of inputs, add or and, optional output negate
module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);
    logic [WIDTH-1:0] x1, x2, y1, y2, r;

    always_comb begin
        x1  = zx ? '0 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y;
        y2  = ny ? ~y1 : y1;
        r   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~r : r;
    end

    assign zr = (out == '0);
    assign ng = out[WIDTH-1];
endmodule

// File: rtl/hack_cpu_core.sv
// rtl/hack_cpu_core.sv - single-cycle Hack CPU datapath/control driving the ALU
module hack_cpu_core
    import hack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    hack_cpu_core_if.master  bus
);
    logic [WIDTH-1:0] a_reg, d_reg, alu_y, alu_out;
    logic [AW-1:0]    pc_reg, pc_inc;
    logic             is_c, zr, ng, jump;
    c_fields_t        fld;

    assign is_c  = bus.instruction[TYPE_BIT];
    assign fld   = decode_c(bus.instruction);
    assign alu_y = fld.a ? bus.inM : a_reg;

    alu #(.WIDTH(WIDTH)) u_alu (
        .x  (d_reg),
        .y  (alu_y),
        .zx (fld.comp[5]),
        .nx (fld.comp[4]),
        .zy (fld.comp[3]),
        .ny (fld.comp[2]),
        .f  (fld.comp[1]),
        .no (fld.comp[0]),
        .out(alu_out),
        .zr (zr),
        .ng (ng)
    );

    assign jump   = is_c & ((fld.lt & ng) | (fld.eq & zr) | (fld.gt & ~ng & ~zr));
    assign pc_inc = pc_reg + AW'(1);

    // Jump target and addressM both use A as it was before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= AW'(PC_RESET);
        end else if (!bus.stall) begin
            if (!is_c) begin
                a_reg  <= WIDTH'({1'b0, bus.instruction[14:0]});
                pc_reg <= pc_inc;
            end else begin
                if (fld.dest_a) a_reg <= alu_out;
                if (fld.dest_d) d_reg <= alu_out;
                pc_reg <= jump ? a_reg[AW-1:0] : pc_inc;
            end
        end
    end

    assign bus.outM     = alu_out;
    assign bus.writeM   = is_c & fld.dest_m & ~bus.stall & ~reset;
    assign bus.addressM = a_reg[AW-1:0];
    assign bus.pc       = pc_reg;
endmodule

// File: tb/tb_hack_cpu_core.sv
// tb/tb_hack_cpu_core.sv - directed vector bench for hack_cpu_core
module tb_hack_cpu_core;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    hack_cpu_core_if #(.WIDTH(16), .AW(15)) bus ();

    hack_cpu_core #(.WIDTH(16), .AW(15)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [15:0] inm;
        logic        stall;
        logic        chk_out;
        logic [15:0] outm;
        logic        wr;
        logic [14:0] addr;
        logic [14:0] pc_next;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] instr, input logic [15:0] inm,
                                input logic stall, input logic chk_out, input logic [15:0] outm,
                                input logic wr, input logic [14:0] addr, input logic [14:0] pc_next);
        vec_t v;
        v.name = name; v.instr = instr; v.inm = inm; v.stall = stall; v.chk_out = chk_out;
        v.outm = outm; v.wr = wr; v.addr = addr; v.pc_next = pc_next;
        return v;
    endfunction

    initial begin
        //                name        instr    inM      st  chk  outM     wr  addr      pc_next
        vecs.push_back(mk("a5",       16'h0005, 16'd0,  0, 0, 16'h0000, 0, 15'd0,    15'd1));
        vecs.push_back(mk("d_eq_a",   16'hEC10, 16'd0,  0, 1, 16'h0005, 0, 15'd5,    15'd2));
        vecs.push_back(mk("a100",     16'h0064, 16'd0,  0, 0, 16'h0000, 0, 15'd5,    15'd3));
        vecs.push_back(mk("m_dp1",    16'hE7C8, 16'd0,  0, 1, 16'h0006, 1, 15'd100,  15'd4));
        vecs.push_back(mk("m_d",      16'hE308, 16'd0,  0, 1, 16'h0005, 1, 15'd100,  15'd5));
        vecs.push_back(mk("a20",      16'h0014, 16'd0,  0, 0, 16'h0000, 0, 15'd100,  15'd6));
        vecs.push_back(mk("jgt_take", 16'hE301, 16'd0,  0, 1, 16'h0005, 0, 15'd20,   15'd20));
        vecs.push_back(mk("d_zero",   16'hEA90, 16'd0,  0, 1, 16'h0000, 0, 15'd20,   15'd21));
        vecs.push_back(mk("jgt_skip", 16'hE301, 16'd0,  0, 1, 16'h0000, 0, 15'd20,   15'd22));
        vecs.push_back(mk("jeq_take", 16'hE302, 16'd0,  0, 1, 16'h0000, 0, 15'd20,   15'd20));
        vecs.push_back(mk("a5b",      16'h0005, 16'd0,  0, 0, 16'h0000, 0, 15'd20,   15'd21));
        vecs.push_back(mk("d_neg_a",  16'hECD0, 16'd0,  0, 1, 16'hFFFB, 0, 15'd5,    15'd22));
        vecs.push_back(mk("a20b",     16'h0014, 16'd0,  0, 0, 16'h0000, 0, 15'd5,    15'd23));
        vecs.push_back(mk("jlt_take", 16'hE304, 16'd0,  0, 1, 16'hFFFB, 0, 15'd20,   15'd20));
        vecs.push_back(mk("a3",       16'h0003, 16'd0,  0, 0, 16'h0000, 0, 15'd20,   15'd21));
        vecs.push_back(mk("am_mm1",   16'hFCA8, 16'd10, 0, 1, 16'h0009, 1, 15'd3,    15'd22));
        vecs.push_back(mk("stall1",   16'hE7C8, 16'd0,  1, 1, 16'hFFFC, 0, 15'd9,    15'd22));
        vecs.push_back(mk("stall2",   16'hE7C8, 16'd0,  1, 1, 16'hFFFC, 0, 15'd9,    15'd22));
        vecs.push_back(mk("post_st",  16'hE308, 16'd0,  0, 1, 16'hFFFB, 1, 15'd9,    15'd23));
        vecs.push_back(mk("a_jmp",    16'hEFE7, 16'd0,  0, 1, 16'h0001, 0, 15'd9,    15'd9));
        vecs.push_back(mk("a7",       16'h0007, 16'd0,  0, 0, 16'h0000, 0, 15'd1,    15'd10));
        vecs.push_back(mk("amd_one",  16'hEFF8, 16'd0,  0, 1, 16'h0001, 1, 15'd7,    15'd11));
        vecs.push_back(mk("amd_chk",  16'hE308, 16'd0,  0, 1, 16'h0001, 1, 15'd1,    15'd12));
        vecs.push_back(mk("a7fff",    16'h7FFF, 16'd0,  0, 0, 16'h0000, 0, 15'd1,    15'd13));
        vecs.push_back(mk("jmp_top",  16'hEA87, 16'd0,  0, 1, 16'h0000, 0, 15'h7FFF, 15'h7FFF));
        vecs.push_back(mk("wrap",     16'h0001, 16'd0,  0, 0, 16'h0000, 0, 15'h7FFF, 15'd0));
        vecs.push_back(mk("post_w1",  16'h0002, 16'd0,  0, 0, 16'h0000, 0, 15'd1,    15'd1));
        vecs.push_back(mk("post_w2",  16'h0003, 16'd0,  0, 0, 16'h0000, 0, 15'd2,    15'd2));

        // Power-on reset with a memory-writing instruction presented.
        reset = 1'b1;
        bus.instruction = 16'hE7C8;
        bus.inM = 16'd0;
        bus.stall = 1'b0;
        #2;
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_addr", 32'(bus.addressM), 32'd0);
        chk("rst_wr", 32'(bus.writeM), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.instruction = vecs[i].instr;
            bus.inM = vecs[i].inm;
            bus.stall = vecs[i].stall;
            #1;
            if (vecs[i].chk_out) chk({vecs[i].name, "_outM"}, 32'(bus.outM), 32'(vecs[i].outm));
            chk({vecs[i].name, "_writeM"}, 32'(bus.writeM), 32'(vecs[i].wr));
            chk({vecs[i].name, "_addressM"}, 32'(bus.addressM), 32'(vecs[i].addr));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_pc"}, 32'(bus.pc), 32'(vecs[i].pc_next));
            @(negedge clk);
        end

        // Mid-run reset: clears immediately, holds across edges, then counts from 0.
        bus.instruction = 16'hE7C8;
        bus.stall = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", 32'(bus.pc), 32'd0);
        chk("mid_rst_addr", 32'(bus.addressM), 32'd0);
        chk("mid_rst_wr", 32'(bus.writeM), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_pc", 32'(bus.pc), 32'd0);
        chk("mid_rst_hold_wr", 32'(bus.writeM), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.instruction = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("post_rst_pc%0d", k), 32'(bus.pc), 32'(k));
            @(posedge clk);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
- Hack CPU datapath/control stage that drives the existing `alu` block.
  - Decodes the 16-bit instruction into ALU control bits.
  - Selects ALU operands: D register for x, A register or inM for y.
  - Consumes ALU out/zr/ng to update A, D, memory and the PC.
- Sits between instruction ROM / data RAM and the ALU.
- Single-cycle execution per instruction, plus a stall input for slow memory.

Parameters:
- WIDTH, 16, data word width (A, D, inM, outM, instruction).
- AW, 15, address width (addressM, pc).

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction  input  16  current instruction fetched at address pc.
- inM  input  16  data RAM read value at addressM.
- stall  input  1  freeze all architectural state this cycle.
- outM  output  16  ALU result; data to write to RAM.
- writeM  output  1  RAM write enable.
- addressM  output  15  RAM address = A[14:0] (current A, before update).
- pc  output  15  address of the next instruction to fetch.

Behaviour:
- Reset state: A=0, D=0, pc=0, applied immediately on reset rise; writeM=0 combinationally while reset=1.
- A-instruction (instruction[15]=0):
  - A <= {1'b0, instruction[14:0]}; D unchanged; writeM=0.
  - pc <= pc+1.
- C-instruction (instruction[15]=1; bits 14:13 are ignored, so 1xx always decodes as C):
  - a=instr[12]; zx,nx,zy,ny,f,no=instr[11:6]; dest A,D,M=instr[5:3]; jump lt,eq,gt=instr[2:0].
  - ALU x=D; ALU y = a ? inM : A.
  - outM = ALU out, combinational, same cycle.
  - writeM = destM & ~stall & ~reset.
  - destA: A <= out. destD: D <= out.
  - jump = (lt&ng) | (eq&zr) | (gt&~ng&~zr).
  - pc <= jump ? A[14:0] (old A) : pc+1.
- Latency: register effects visible the cycle after the edge; outM/writeM/addressM are combinational from current state and inputs.
- Simultaneous events:
  - dest includes A together with a jump: jump target and addressM use the pre-update A.
  - Dest AMD: all three see the same out.
- stall=1: A, D, pc hold; writeM=0; outM still reflects the ALU.
- PC wrap: 0x7FFF+1 -> 0x0000 (15-bit modulo).
- Reset asserted mid-operation: state cleared asynchronously and held while reset=1; first instruction after deassert is fetched from pc=0.
- No FSM beyond the PC sequencer; the stall gating is the only handshake.

Decomposition:
- hack_pkg: instruction field bit positions (TYPE_BIT=15, A_BIT=12, COMP_MSB/LSB=11/6, DEST_MSB/LSB=5/3, JMP_MSB/LSB=2/0), WIDTH/AW defaults, PC_RESET=0.
- Sub-module: instantiate the existing `alu` unchanged.
- PC increment/jump mux stays inline.

Test Plan:
- Reset mid-run: after 3 instructions assert reset -> pc=0, addressM=0, writeM=0 with no clock edge; hold 2 cycles, deassert -> pc then counts 0,1,2.
- Sequence 0x0005 (@5), 0xEC10 (D=A) -> A=5, D=5; pc 0->1->2; writeM=0 throughout.
- Store: with D=5, 0x0064 (@100), then 0xE7C8 (M=D+1) -> during the C cycle outM=6, writeM=1, addressM=100; D unchanged.
- Jumps: A=20, D=5, 0xE301 (D;JGT) -> pc=20. With D=0, 0xE301 -> pc+1; 0xE302 (D;JEQ) -> pc=20. D=0xFFFB, 0xE304 (D;JLT) -> pc=20.
- Read-modify-write: A=3, inM=10, 0xFCA8 (AM=M-1) -> outM=9, writeM=1, addressM=3 this cycle; next cycle A=9, addressM=9.
- Stall + wrap: stall=1 during 0xE7C8 -> writeM=0; A, D, pc unchanged for 2 cycles. Reaching pc=0x7FFF with A-instruction 0x0001 -> next pc=0x0000.
